// File: rtl/mem_port_if.sv
// mem_port_if: one requester's handshake to the memory port arbiter
interface mem_port_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between two requesters
module mem_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_if.slave         p0,
  mem_port_if.slave         p1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_sig,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              grant_id
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  logic [1:0] state;
  logic       last_grant;
  logic       any_req;
  logic       pick;
  always_comb begin
    any_req = p0.req | p1.req;
    pick    = (p0.req && p1.req) ? (FIXED_PRIO ? 1'b0 : ~last_grant) : p1.req;
  end
  assign busy = state != IDLE;
  // mem_write_sig doubles as the latched write enable while in ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write_sig  <= 1'b0;
      p0.ack         <= 1'b0;
      p1.ack         <= 1'b0;
      p0.rdata       <= '0;
      p1.rdata       <= '0;
    end else begin
      mem_write_sig <= 1'b0;
      p0.ack        <= 1'b0;
      p1.ack        <= 1'b0;
      if (state == IDLE && any_req) begin
        state          <= ACCESS;
        grant_id       <= pick;
        last_grant     <= pick;
        mem_address    <= pick ? p1.addr : p0.addr;
        mem_write_data <= pick ? p1.wdata : p0.wdata;
        mem_write_sig  <= pick ? p1.we : p0.we;
      end else if (state == ACCESS) begin
        state <= DONE;
        if (!mem_write_sig && grant_id) p1.rdata <= mem_read_data;
        if (!mem_write_sig && !grant_id) p0.rdata <= mem_read_data;
        p0.ack <= ~grant_id;
        p1.ack <= grant_id;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of round-robin and fixed-priority arbiters
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_if #(.ADDR_W(5), .DATA_W(8)) a0 ();
  mem_port_if #(.ADDR_W(5), .DATA_W(8)) a1 ();
  mem_port_if #(.ADDR_W(5), .DATA_W(8)) b0 ();
  mem_port_if #(.ADDR_W(5), .DATA_W(8)) b1 ();
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wd, b_wd, a_rd, b_rd;
  logic       a_ws, b_ws, a_busy, b_busy, a_gid, b_gid;
  int total = 0;
  int fails = 0;
  bit [7:0]  wa [32];
  bit [7:0]  wb [32];
  bit [31:0] va = '0;
  bit [31:0] vb = '0;
  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .p0(a0), .p1(a1),
    .mem_address(a_addr), .mem_write_data(a_wd), .mem_write_sig(a_ws),
    .mem_read_data(a_rd), .busy(a_busy), .grant_id(a_gid));
  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .p0(b0), .p1(b1),
    .mem_address(b_addr), .mem_write_data(b_wd), .mem_write_sig(b_ws),
    .mem_read_data(b_rd), .busy(b_busy), .grant_id(b_gid));
  // memory models: written words override a small preloaded image
  assign a_rd = va[a_addr] ? wa[a_addr] : (a_addr == 5'd15 ? 8'hAA : a_addr == 5'd17 ? 8'h02 : 8'h00);
  assign b_rd = vb[b_addr] ? wb[b_addr] : (b_addr == 5'd1 ? 8'h11 : b_addr == 5'd2 ? 8'h22 : 8'h00);
  always @(posedge clk) begin
    if (a_ws) begin
      wa[a_addr] <= a_wd;
      va[a_addr] <= 1'b1;
    end
    if (b_ws) begin
      wb[b_addr] <= b_wd;
      vb[b_addr] <= 1'b1;
    end
  end
  function automatic logic [7:0] mem_a(input logic [4:0] ad);
    return va[ad] ? wa[ad] : 8'h00;
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 5'd15; a0.wdata = 8'h00;
    a1.req = 1'b1; a1.we = 1'b0; a1.addr = 5'd17; a1.wdata = 8'h00;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = 5'd0;  b0.wdata = 8'h00;
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = 5'd0;  b1.wdata = 8'h00;
    #12;
    chk("rst_busy", a_busy, 0);
    chk("rst_gid", a_gid, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wd, 0);
    chk("rst_ws", a_ws, 0);
    chk("rst_ack0", a0.ack, 0);
    chk("rst_ack1", a1.ack, 0);
    chk("rst_rdata0", a0.rdata, 0);
    chk("rst_rdata1", a1.rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("c1_gid", a_gid, 0);
    chk("c1_busy", a_busy, 1);
    chk("c1_addr", a_addr, 5'd15);
    chk("c1_ws", a_ws, 0);
    tick();
    chk("c1_ack0", a0.ack, 1);
    chk("c1_ack1", a1.ack, 0);
    chk("c1_rdata0", a0.rdata, 8'hAA);
    tick();
    chk("c1_idle", a_busy, 0);
    chk("c1_ack0_low", a0.ack, 0);
    tick();
    chk("c2_gid", a_gid, 1);
    chk("c2_addr", a_addr, 5'd17);
    tick();
    chk("c2_ack1", a1.ack, 1);
    chk("c2_ack0", a0.ack, 0);
    chk("c2_rdata1", a1.rdata, 8'h02);
    chk("c2_rdata0", a0.rdata, 8'hAA);
    tick();
    tick();
    chk("c3_gid", a_gid, 0);
    tick();
    chk("c3_ack0", a0.ack, 1);
    tick();
    tick();
    chk("c4_gid", a_gid, 1);
    a0.req = 1'b0;
    tick();
    chk("c4_ack1", a1.ack, 1);
    a1.req = 1'b0;
    tick();
    tick();
    chk("c_quiet", a_busy, 0);
    a1.we = 1'b1; a1.addr = 5'd16; a1.wdata = 8'hA5; a1.req = 1'b1;
    tick();
    chk("w_ws", a_ws, 1);
    chk("w_gid", a_gid, 1);
    chk("w_addr", a_addr, 5'd16);
    chk("w_wdata", a_wd, 8'hA5);
    tick();
    chk("w_ws_off", a_ws, 0);
    chk("w_ack1", a1.ack, 1);
    chk("w_mem16", mem_a(5'd16), 8'hA5);
    chk("w_rdata1_kept", a1.rdata, 8'h02);
    a1.req = 1'b0;
    tick();
    a1.we = 1'b0; a1.req = 1'b1;
    tick();
    chk("r_ws", a_ws, 0);
    tick();
    chk("r_ack1", a1.ack, 1);
    chk("r_rdata1", a1.rdata, 8'hA5);
    a1.req = 1'b0;
    tick();
    a0.we = 1'b1; a0.addr = 5'd3; a0.wdata = 8'h3C; a0.req = 1'b1;
    tick();
    a0.addr = 5'd4; a0.wdata = 8'hFF; a0.req = 1'b0;
    chk("f_addr", a_addr, 5'd3);
    chk("f_wdata", a_wd, 8'h3C);
    chk("f_ws", a_ws, 1);
    tick();
    chk("f_ack0", a0.ack, 1);
    chk("f_mem3", mem_a(5'd3), 8'h3C);
    chk("f_mem4", mem_a(5'd4), 8'h00);
    tick();
    chk("f_idle", a_busy, 0);
    tick();
    chk("f_idle2", a_busy, 0);
    a0.addr = 5'd8; a0.wdata = 8'h77; a0.we = 1'b1; a0.req = 1'b1;
    tick();
    chk("x_ws_pre", a_ws, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("x_ws_async", a_ws, 0);
    chk("x_busy_async", a_busy, 0);
    a0.req = 1'b0;
    tick();
    chk("x_mem8", mem_a(5'd8), 8'h00);
    chk("x_no_ack", a0.ack, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("x_idle", a_busy, 0);
    chk("x_no_ack2", a0.ack, 0);
    chk("x_mem8_after", mem_a(5'd8), 8'h00);
    b0.addr = 5'd1; b0.req = 1'b1;
    b1.addr = 5'd2; b1.req = 1'b1;
    tick();
    chk("p_gid1", b_gid, 0);
    tick();
    chk("p_ack0_1", b0.ack, 1);
    chk("p_rdata0", b0.rdata, 8'h11);
    tick();
    tick();
    chk("p_gid2", b_gid, 0);
    tick();
    chk("p_ack0_2", b0.ack, 1);
    chk("p_ack1_2", b1.ack, 0);
    tick();
    tick();
    chk("p_gid3", b_gid, 0);
    b0.req = 1'b0;
    tick();
    chk("p_ack0_3", b0.ack, 1);
    tick();
    tick();
    chk("p_gid4", b_gid, 1);
    chk("p_addr4", b_addr, 5'd2);
    tick();
    chk("p_ack1_4", b1.ack, 1);
    chk("p_ack0_4", b0.ack, 0);
    chk("p_rdata1", b1.rdata, 8'h22);
    b1.req = 1'b0;
    tick();
    chk("p_idle", b_busy, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
